// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by decode, operand fetch and execute:
//   DATA_W   - datapath width (16)
//   REG_AW   - register address width (3, eight registers)
//   OP_W     - opcode width (4)
//   NUM_REGS - number of architectural registers
//   op_e     - opcode encoding
//   reg_onehot() - one-hot decode of a register address
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int OP_W     = 4;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_LD  = 4'h7,
        OP_ST  = 4'h8,
        OP_BEQ = 4'h9,
        OP_NOP = 4'hF
    } op_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Tracks which registers have a write in flight beyond operand fetch and
// answers hazard queries for the instruction currently being decoded.
//
// Build option: OPERAND_FWD_EN -- when defined, a source register that is
// being written back in this very cycle is forwarded instead of stalling.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   set_en, set_rd      mark set_rd pending (instruction left for execute)
//   clr_en, clr_rd      clear clr_rd pending (writeback retires)
//   src_a, src_b        source registers of the incoming instruction
//   dst, dst_wr         destination of the incoming instruction
//   stage_valid/wr/rd   contents of the output stage (not yet pending)
//   hazard_a, hazard_b  source cannot be read yet
//   waw                 destination collides with an in-flight write
//   fwd_a, fwd_b        source must take the writeback data this cycle
// ---------------------------------------------------------------------------
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] src_a,
    input  logic [REG_AW-1:0] src_b,
    input  logic [REG_AW-1:0] dst,
    input  logic              dst_wr,
    input  logic              stage_valid,
    input  logic              stage_wr,
    input  logic [REG_AW-1:0] stage_rd,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              waw,
    output logic              fwd_a,
    output logic              fwd_b
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic                stage_writes;

    assign set_mask = set_en ? reg_onehot(set_rd) : '0;
    assign clr_mask = clr_en ? reg_onehot(clr_rd) : '0;

    // Clear first, then OR in the set: a register that retires and is
    // re-issued in the same cycle stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign stage_writes = stage_valid & stage_wr;

`ifdef OPERAND_FWD_EN
    assign fwd_a = clr_en & (clr_rd == src_a);
    assign fwd_b = clr_en & (clr_rd == src_b);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    // The output stage has not set its pending bit yet, so it is checked
    // separately; forwarding cannot cover it because its value is not
    // on the writeback port.
    assign hazard_a = (pending[src_a] & ~fwd_a) | (stage_writes & (stage_rd == src_a));
    assign hazard_b = (pending[src_b] & ~fwd_b) | (stage_writes & (stage_rd == src_b));

    assign waw = dst_wr & (pending[dst] | (stage_writes & (stage_rd == dst)));

endmodule

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
// Reads both source operands of a decoded instruction from the register
// file, holds back instructions with RAW/WAW hazards against in-flight
// writes, and presents op/rd/operands to execute through a one-entry
// output register (one cycle of latency).
//
// Build option: OPERAND_FWD_EN -- when defined, operands being written back
// in the current cycle are taken from wb_wd rather than stalling.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. valid, once raised, stays high with stable payload until the
// transfer; ready may depend combinationally on the receiving side.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid, in_ready         decoded-instruction handshake
//   in_op, in_ra, in_rb,
//   in_rd, in_wr               decoded instruction fields
//   rf_a1, rf_a2               register-file read addresses (= in_ra/in_rb)
//   rf_rd1, rf_rd2             register-file read data (combinational)
//   wb_we, wb_a3, wb_wd        snooped register-file write port
//   flush                      kill the output-stage instruction
//   out_valid, out_ready       execute handshake
//   out_op, out_rd, out_wr,
//   out_opa, out_opb           instruction presented to execute
// ---------------------------------------------------------------------------
module operand_fetch
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_AW-1:0] in_ra,
    input  logic [REG_AW-1:0] in_rb,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wr,
    output logic [REG_AW-1:0] rf_a1,
    output logic [REG_AW-1:0] rf_a2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_a3,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wr,
    output logic [DATA_W-1:0] out_opa,
    output logic [DATA_W-1:0] out_opb
);

    logic              hazard_a;
    logic              hazard_b;
    logic              waw;
    logic              fwd_a;
    logic              fwd_b;
    logic              out_fire;
    logic              in_fire;
    logic [DATA_W-1:0] opa_next;
    logic [DATA_W-1:0] opb_next;

    assign rf_a1 = in_ra;
    assign rf_a2 = in_rb;

    // A flushed instruction never reaches execute, so it must not mark its
    // destination pending (nothing would ever retire it).
    assign out_fire = out_valid & out_ready & ~flush;

    reg_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_en      (out_fire & out_wr),
        .set_rd      (out_rd),
        .clr_en      (wb_we),
        .clr_rd      (wb_a3),
        .src_a       (in_ra),
        .src_b       (in_rb),
        .dst         (in_rd),
        .dst_wr      (in_wr),
        .stage_valid (out_valid),
        .stage_wr    (out_wr),
        .stage_rd    (out_rd),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .waw         (waw),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    assign in_ready = ~(hazard_a | hazard_b | waw)
                    & (~out_valid | out_ready)
                    & ~flush
                    & ~rst;

    assign in_fire = in_valid & in_ready;

    // fwd_* are tied low when forwarding is not built in.
    assign opa_next = fwd_a ? wb_wd : rf_rd1;
    assign opb_next = fwd_b ? wb_wd : rf_rd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_rd    <= '0;
            out_wr    <= 1'b0;
            out_opa   <= '0;
            out_opb   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_rd    <= in_rd;
            out_wr    <= in_wr;
            out_opa   <= opa_next;
            out_opb   <= opb_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
// Directed bench for operand_fetch. The register file is modelled here and
// is reset to known contents (r1=r2=20, rN=0xA000+N otherwise), so every
// expected operand below is a hand-derived constant.
// ---------------------------------------------------------------------------
module tb_operand_fetch;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_ra;
    logic [2:0]  in_rb;
    logic [2:0]  in_rd;
    logic        in_wr;
    logic [2:0]  rf_a1;
    logic [2:0]  rf_a2;
    logic [15:0] rf_rd1;
    logic [15:0] rf_rd2;
    logic        wb_we;
    logic [2:0]  wb_a3;
    logic [15:0] wb_wd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [2:0]  out_rd;
    logic        out_wr;
    logic [15:0] out_opa;
    logic [15:0] out_opb;

    int checks;
    int errors;
    logic [39:0] exp_q[$];

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_rd     (in_rd),
        .in_wr     (in_wr),
        .rf_a1     (rf_a1),
        .rf_a2     (rf_a2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .wb_we     (wb_we),
        .wb_a3     (wb_a3),
        .wb_wd     (wb_wd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_rd    (out_rd),
        .out_wr    (out_wr),
        .out_opa   (out_opa),
        .out_opb   (out_opb)
    );

    // ---------------- clock / reset / register file model ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] rf [8];

    function automatic logic [15:0] rf_init(input int i);
        if (i == 1 || i == 2) return 16'd20;
        return 16'hA000 + 16'(i);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_init(i);
        end else if (wb_we) begin
            rf[wb_a3] <= wb_wd;
        end
    end

    assign rf_rd1 = rf[rf_a1];
    assign rf_rd2 = rf[rf_a2];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_in(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                            input logic [2:0] rd, input logic wr);
        in_valid = 1'b1;
        in_op    = op;
        in_ra    = ra;
        in_rb    = rb;
        in_rd    = rd;
        in_wr    = wr;
    endtask

    // ---------------- scoreboard ----------------
    function automatic logic [39:0] out_bus();
        return {out_op, out_rd, out_wr, out_opa, out_opb};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [3:0] op, input logic [2:0] rd, input logic wr,
                              input logic [15:0] opa, input logic [15:0] opb);
        exp_q.push_back({op, rd, wr, opa, opb});
    endtask

    task automatic check_out(input string tag);
        logic [39:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hx;
        chk1({tag, "_valid"}, out_valid, 1'b1);
        chkw(tag, out_bus(), exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0; in_rd = '0;
        in_wr = 1'b0; wb_we = 1'b0; wb_a3 = '0; wb_wd = '0; flush = 1'b1; out_ready = 1'b1;

        // Reset dominates a pending transfer and a flush.
        drive_in(OP_ADD, 3'd1, 3'd2, 3'd1, 1'b1);
        settle();
        chk1("rst_in_ready", in_ready, 1'b0);
        tick();
        tick();
        settle();
        chk1("rst_out_valid", out_valid, 1'b0);
        chkw("rst_out_data", out_bus(), 40'h0);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();

        // Basic fetch, one-cycle latency.
        drive_in(OP_ADD, 3'd1, 3'd2, 3'd7, 1'b0);
        settle();
        chkw("rf_addr", {34'h0, rf_a1, rf_a2}, {34'h0, 3'd1, 3'd2});
        chk1("basic_in_ready", in_ready, 1'b1);
        chk1("basic_pre_valid", out_valid, 1'b0);
        expect_out(OP_ADD, 3'd7, 1'b0, 16'd20, 16'd20);
        tick();
        in_valid = 1'b0;
        settle();
        check_out("basic_out");
        tick();
        settle();
        chk1("basic_drained", out_valid, 1'b0);

        // RAW on r3 resolved by writeback.
        drive_in(OP_SUB, 3'd1, 3'd2, 3'd3, 1'b1);
        settle();
        chk1("w3_in_ready", in_ready, 1'b1);
        expect_out(OP_SUB, 3'd3, 1'b1, 16'd20, 16'd20);
        tick();
        in_valid = 1'b0;
        settle();
        check_out("w3_out");
        tick();
        drive_in(OP_OR, 3'd3, 3'd1, 3'd0, 1'b0);
        settle();
        chk1("raw_stall0", in_ready, 1'b0);
        tick();
        settle();
        chk1("raw_stall1", in_ready, 1'b0);
        wb_we = 1'b1; wb_a3 = 3'd3; wb_wd = 16'h1234;
        settle();
`ifdef OPERAND_FWD_EN
        chk1("raw_fwd_ready", in_ready, 1'b1);
        expect_out(OP_OR, 3'd0, 1'b0, 16'h1234, 16'd20);
        tick();
        wb_we = 1'b0; in_valid = 1'b0;
        settle();
        check_out("raw_fwd_out");
`else
        chk1("raw_wb_cycle", in_ready, 1'b0);
        tick();
        wb_we = 1'b0;
        settle();
        chk1("raw_after_wb", in_ready, 1'b1);
        expect_out(OP_OR, 3'd0, 1'b0, 16'h1234, 16'd20);
        tick();
        in_valid = 1'b0;
        settle();
        check_out("raw_rf_out");
`endif
        tick();
        settle();
        chk1("raw_drained", out_valid, 1'b0);

        // Back-pressure: hold for three cycles, transfer on first ready.
        out_ready = 1'b0;
        drive_in(OP_AND, 3'd4, 3'd5, 3'd0, 1'b0);
        settle();
        chk1("bp_in_ready", in_ready, 1'b1);
        tick();
        drive_in(OP_ADD, 3'd1, 3'd2, 3'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk1("bp_hold_valid", out_valid, 1'b1);
            chkw("bp_hold_data", out_bus(), {OP_AND, 3'd0, 1'b0, 16'hA004, 16'hA005});
            chk1("bp_hold_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        settle();
        chk1("bp_release_ready", in_ready, 1'b1);
        expect_out(OP_AND, 3'd0, 1'b0, 16'hA004, 16'hA005);
        check_out("bp_release_out");
        expect_out(OP_ADD, 3'd1, 1'b0, 16'd20, 16'd20);
        tick();
        in_valid = 1'b0;
        settle();
        check_out("bp_next_out");
        tick();

        // WAW on r5: pending bit, then stage match.
        drive_in(OP_XOR, 3'd1, 3'd2, 3'd5, 1'b1);
        settle();
        chk1("waw_first_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        drive_in(OP_ADD, 3'd1, 3'd2, 3'd5, 1'b1);
        settle();
        chk1("waw_pending0", in_ready, 1'b0);
        tick();
        settle();
        chk1("waw_pending1", in_ready, 1'b0);
        wb_we = 1'b1; wb_a3 = 3'd5; wb_wd = 16'h0055;
        settle();
        chk1("waw_retire_cycle", in_ready, 1'b0);
        tick();
        wb_we = 1'b0;
        settle();
        chk1("waw_retired", in_ready, 1'b1);
        expect_out(OP_ADD, 3'd5, 1'b1, 16'd20, 16'd20);
        tick();
        drive_in(OP_SUB, 3'd1, 3'd2, 3'd5, 1'b1);
        settle();
        check_out("waw_out");
        chk1("waw_stage", in_ready, 1'b0);
        in_valid = 1'b0;
        tick();
        wb_we = 1'b1; wb_a3 = 3'd5; wb_wd = 16'h0055;
        tick();
        wb_we = 1'b0;

        // Flush kills the output stage without marking r6 pending.
        out_ready = 1'b0;
        drive_in(OP_SUB, 3'd1, 3'd2, 3'd6, 1'b1);
        settle();
        chk1("fl_in_ready", in_ready, 1'b1);
        tick();
        drive_in(OP_XOR, 3'd1, 3'd2, 3'd0, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        settle();
        chk1("fl_pre_valid", out_valid, 1'b1);
        chk1("fl_no_accept", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        chk1("fl_killed", out_valid, 1'b0);
        drive_in(OP_AND, 3'd6, 3'd1, 3'd0, 1'b0);
        settle();
        chk1("fl_r6_free", in_ready, 1'b1);
        expect_out(OP_AND, 3'd0, 1'b0, 16'hA006, 16'd20);
        tick();
        in_valid = 1'b0;
        settle();
        check_out("fl_r6_out");
        tick();

        // Same-cycle set and clear of r4: set wins.
        drive_in(OP_OR, 3'd1, 3'd2, 3'd4, 1'b1);
        settle();
        chk1("sc_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        wb_we = 1'b1; wb_a3 = 3'd4; wb_wd = 16'h4444;
        tick();
        wb_we = 1'b0;
        drive_in(OP_ADD, 3'd4, 3'd1, 3'd0, 1'b0);
        settle();
        chk1("sc_set_wins0", in_ready, 1'b0);
        tick();
        settle();
        chk1("sc_set_wins1", in_ready, 1'b0);

        // Reset in the middle of a stall with an instruction held.
        out_ready = 1'b0;
        drive_in(OP_SUB, 3'd1, 3'd2, 3'd0, 1'b0);
        settle();
        chk1("mr_load_ready", in_ready, 1'b1);
        tick();
        drive_in(OP_ADD, 3'd4, 3'd1, 3'd0, 1'b0);
        settle();
        chk1("mr_held_valid", out_valid, 1'b1);
        chk1("mr_stalled", in_ready, 1'b0);
        rst = 1'b1;
        settle();
        chk1("mr_rst_in_ready", in_ready, 1'b0);
        tick();
        settle();
        chk1("mr_out_valid", out_valid, 1'b0);
        chkw("mr_out_data", out_bus(), 40'h0);
        rst = 1'b0; out_ready = 1'b1;
        settle();
        chk1("mr_pending_cleared", in_ready, 1'b1);
        expect_out(OP_ADD, 3'd0, 1'b0, 16'hA004, 16'd20);
        tick();
        in_valid = 1'b0;
        settle();
        check_out("mr_after_out");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid/in_ready  in/out  1/1  decoded-instruction handshake.
REQ-005 in_op  in  4  opcode; in_ra, in_rb, in_rd  in  3 each  source A, source B, destination; in_wr  in  1  instruction writes in_rd.
REQ-006 rf_a1, rf_a2  out  3 each  register-file read addresses; rf_rd1, rf_rd2  in  16 each  register-file read data (combinational).
REQ-007 wb_we  in  1, wb_a3  in  3, wb_wd  in  16  writeback port snooped (same signals driving the register-file write).
REQ-008 flush  in  1  kill the output-stage instruction.
REQ-009 out_valid/out_ready  out/in  1/1  execute handshake; out_op 4, out_rd 3, out_wr 1, out_opa 16, out_opb 16  out.

Function
REQ-010 rf_a1 SHALL equal in_ra, and rf_a2 SHALL equal in_rb, combinationally.
REQ-011 An 8-bit pending mask SHALL hold one bit per register, meaning a write is in flight beyond this stage.
REQ-012 The pending bit of out_rd SHALL be set on an output transfer (out_valid & out_ready & out_wr).
REQ-013 The pending bit of wb_a3 SHALL be cleared when wb_we=1; if set and clear hit the same register in the same cycle, set SHALL win.
REQ-014 A source SHALL be hazardous if it has its pending bit set, or if it equals out_rd while out_valid & out_wr.
REQ-015 WAW: an incoming instruction with in_wr=1 SHALL stall if in_rd is pending or equals a valid writing out_rd.
REQ-016 in_ready SHALL be (no hazard, no WAW) & (~out_valid | out_ready) & ~flush.
REQ-017 On in_valid & in_ready the output register SHALL load op/rd/wr and operands, setting out_valid=1 on the next cycle, for 1-cycle latency.
REQ-018 The output register SHALL hold its contents stable while out_valid & ~out_ready.
REQ-019 flush=1 SHALL clear out_valid next cycle, accept no input that cycle, and leave the pending mask unchanged.
REQ-020 Operands SHALL be taken as a full 16-bit copy with no arithmetic.

Reset
REQ-021 In a cycle with rst=1, out_valid, pending and all out_* data SHALL be 0 after the edge, and in_ready SHALL be 0.
REQ-022 rst SHALL override flush and transfers, and a mid-stall reset SHALL discard the held instruction.

Configuration
REQ-023 Macro OPERAND_FWD_EN defined: if wb_we & wb_a3==src, that source SHALL take wb_wd, SHALL NOT count as a pending hazard, and SHALL NOT stall.
REQ-024 OPERAND_FWD_EN undefined: no bypass; the source SHALL stall until the cycle after its pending bit clears, then read rf_rd*.

Structure
REQ-025 Package cpu_pkg SHALL define DATA_W=16, REG_AW=3, OP_W=4, and the opcode enum shared with decode and execute.
REQ-026 The pending mask, its set/clear logic and the hazard lookup SHALL be in sub-module reg_scoreboard.

Verification
REQ-027 Reset, then send op with ra=1, rb=2, rf=20/20 -> out_opa=20, out_opb=20, out_valid one cycle after the transfer.
REQ-028 Issue write to r3 and drain it; next instruction with ra=3 -> stalls; wb_we, a3=3, wd=0x1234 -> FWD_EN: issues that cycle with opa=0x1234; without it: issues next cycle reading 0x1234.
REQ-029 Hold out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0, and the transfer completes on the first ready cycle.
REQ-030 WAW: r5 write pending, then a new in_wr with in_rd=5 -> in_ready=0 until wb_a3=5 retires.
REQ-031 Assert flush with out_valid=1, rd=6 -> out_valid=0 next cycle, pending[6] stays 0, and no input is accepted that cycle.
REQ-032 Same-cycle set of r4 with wb clear of r4 -> pending[4]=1; assert rst mid-stall -> all outputs 0 next cycle.
